// File: rtl/apb_uart_pkg.sv
// Shared constants and types for the APB host that drives the UART receiver.
package apb_uart_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BP_W   = 14;
    localparam int unsigned BP_HI_W = BP_W - DATA_W;
    localparam int unsigned DS_W   = 4;
    localparam int unsigned ERR_W  = 2;

    // Receiver register map
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_ERROR  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_BP_LO  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_BP_HI  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_DSIZE  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd6;

    // Receiver error-register codes
    localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_FRAMING = 2'd1;
    localparam logic [ERR_W-1:0] ERR_OVERRUN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_BPL,
        ST_CFG_BPH,
        ST_CFG_DS,
        ST_POLL,
        ST_RD_ERR,
        ST_RD_DATA
    } main_state_t;

    typedef enum logic [1:0] {
        XS_IDLE,
        XS_SETUP,
        XS_ACCESS
    } xfer_state_t;

    // One request to the transfer engine
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_req_t;

endpackage

// File: rtl/apb_xfer.sv
// Single APB transfer engine: SETUP then ACCESS, zero wait states.
// A request taken during the completion cycle starts the next SETUP with no gap.
module apb_xfer
    import apb_uart_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    xfer_state_t state;

    // Phase sequencing with registered APB controls; address/data hold between transfers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= XS_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            case (state)
                XS_SETUP: begin
                    state   <= XS_ACCESS;
                    penable <= 1'b1;
                end
                default: begin
                    if (req) begin
                        state   <= XS_SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= wr;
                        paddr   <= addr;
                        if (wr) begin
                            pwdata <= wdata;
                        end
                    end else begin
                        state   <= XS_IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Responder has no pready, so every ACCESS cycle is the completion cycle
    assign done  = (state == XS_ACCESS);
    assign rdata = prdata;
    assign err   = pslverr;

endmodule

// File: rtl/apb_uart_host.sv
// Host-side APB initiator for the UART receiver: configure, poll status,
// then fetch error and data registers and present each byte with a strobe.
module apb_uart_host
    import apb_uart_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              stop,
    input  logic [BP_W-1:0]   cfg_bit_period,
    input  logic [DS_W-1:0]   cfg_data_size,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr,
    output logic [DATA_W-1:0] rx_byte,
    output logic [ERR_W-1:0]  rx_error,
    output logic              rx_valid,
    output logic              cfg_done,
    output logic              busy,
    output logic              bus_error
);

    main_state_t          state;
    main_state_t          state_nxt;
    logic [BP_HI_W-1:0]   bp_hi_q;
    logic [DS_W-1:0]      ds_q;
    logic [ERR_W-1:0]     err_cap;

    xfer_req_t            xreq;
    logic                 req;
    logic                 done;
    logic                 xerr;
    logic [DATA_W-1:0]    rdata;

    apb_xfer u_xfer (
        .clk     (clk),
        .n_rst   (n_rst),
        .req     (req),
        .wr      (xreq.wr),
        .addr    (xreq.addr),
        .wdata   (xreq.wdata),
        .done    (done),
        .rdata   (rdata),
        .err     (xerr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pslverr (pslverr)
    );

    // Next state, and the transfer to launch when entering it
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        xreq      = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CFG_BPL;
                end
            end
            default: begin
                if (done) begin
                    if (xerr) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        case (state)
                            ST_CFG_BPL: state_nxt = ST_CFG_BPH;
                            ST_CFG_BPH: state_nxt = ST_CFG_DS;
                            ST_CFG_DS:  state_nxt = ST_POLL;
                            ST_POLL: begin
                                if (stop) begin
                                    state_nxt = ST_IDLE;
                                end else if (rdata[0]) begin
                                    state_nxt = ST_RD_ERR;
                                end else begin
                                    state_nxt = ST_POLL;
                                end
                            end
                            ST_RD_ERR:  state_nxt = ST_RD_DATA;
                            ST_RD_DATA: state_nxt = stop ? ST_IDLE : ST_POLL;
                            default:    state_nxt = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase

        // The low bit-period byte goes straight from the input; capture lands on the same edge
        req = (state_nxt != ST_IDLE) && ((state == ST_IDLE) ? start : done);
        case (state_nxt)
            ST_CFG_BPL: xreq = '{wr: 1'b1, addr: ADDR_BP_LO,  wdata: cfg_bit_period[DATA_W-1:0]};
            ST_CFG_BPH: xreq = '{wr: 1'b1, addr: ADDR_BP_HI,  wdata: DATA_W'(bp_hi_q)};
            ST_CFG_DS:  xreq = '{wr: 1'b1, addr: ADDR_DSIZE,  wdata: DATA_W'(ds_q)};
            ST_POLL:    xreq = '{wr: 1'b0, addr: ADDR_STATUS, wdata: '0};
            ST_RD_ERR:  xreq = '{wr: 1'b0, addr: ADDR_ERROR,  wdata: '0};
            ST_RD_DATA: xreq = '{wr: 1'b0, addr: ADDR_DATA,   wdata: '0};
            default:    xreq = '0;
        endcase
    end

    // State, captured configuration and registered host-side outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            bp_hi_q   <= '0;
            ds_q      <= '0;
            err_cap   <= ERR_NONE;
            rx_byte   <= '0;
            rx_error  <= ERR_NONE;
            rx_valid  <= 1'b0;
            cfg_done  <= 1'b0;
            busy      <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != ST_IDLE);
            cfg_done <= 1'b0;
            rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bp_hi_q   <= cfg_bit_period[BP_W-1:DATA_W];
                        ds_q      <= cfg_data_size;
                        bus_error <= 1'b0;
                    end
                end
                ST_CFG_DS: begin
                    if (done && !xerr) begin
                        cfg_done <= 1'b1;
                    end
                end
                ST_RD_ERR: begin
                    if (done && !xerr) begin
                        err_cap <= rdata[ERR_W-1:0];
                    end
                end
                ST_RD_DATA: begin
                    if (done && !xerr) begin
                        rx_byte  <= rdata;
                        rx_error <= err_cap;
                        rx_valid <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (done && xerr) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_host.sv
// Bench for apb_uart_host: a behavioural UART-receiver responder feeds bytes,
// expected transfers/bytes go into queues, and a monitor checks them as they appear.
`timescale 1ns/1ps
module tb_apb_uart_host;
    import apb_uart_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic        stop_stim = 1'b0;
    logic        stop_rsp = 1'b0;
    logic        stop;
    logic [13:0] cfg_bit_period = '0;
    logic [3:0]  cfg_data_size = '0;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata = '0;
    logic        pslverr = 1'b0;
    logic [7:0]  rx_byte;
    logic [1:0]  rx_error;
    logic        rx_valid, cfg_done, busy, bus_error;

    assign stop = stop_stim | stop_rsp;

    apb_uart_host dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .stop           (stop),
        .cfg_bit_period (cfg_bit_period),
        .cfg_data_size  (cfg_data_size),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .prdata         (prdata),
        .pslverr        (pslverr),
        .rx_byte        (rx_byte),
        .rx_error       (rx_error),
        .rx_valid       (rx_valid),
        .cfg_done       (cfg_done),
        .busy           (busy),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int unsigned addr; int unsigned wdata; int cyc; } bus_t;
    typedef struct { int unsigned data; int unsigned err; int cyc; } rx_t;
    typedef struct { int polls; int unsigned err; int unsigned data; } offer_t;

    bus_t   exp_bus[$];
    rx_t    exp_rx[$];
    int     exp_cfg[$];
    offer_t offer_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit inj_en = 1'b0;
    int unsigned inj_addr = 0;
    bit stop_on_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Receiver model: answers ACCESS reads and predicts what the host must do next
    always @(negedge clk) begin
        pslverr = 1'b0;
        if (!busy && !psel) stop_rsp = 1'b0;
        if (psel && penable) begin
            if (inj_en && paddr == 3'(inj_addr)) begin
                pslverr = 1'b1;
                inj_en  = 1'b0;
                prdata  = 8'($urandom);
            end else begin
                case (paddr)
                    ADDR_STATUS: begin
                        if (offer_q.size() > 0 && offer_q[0].polls == 0 && !stop) begin
                            prdata = 8'($urandom) | 8'h01;
                            exp_bus.push_back('{1'b0, 32'(ADDR_ERROR), 0, cyc + 2});
                            exp_bus.push_back('{1'b0, 32'(ADDR_DATA), 0, cyc + 4});
                            exp_rx.push_back('{offer_q[0].data, offer_q[0].err, cyc + 5});
                        end else begin
                            prdata = 8'($urandom) & 8'hFE;
                            if (offer_q.size() > 0 && offer_q[0].polls > 0) offer_q[0].polls--;
                            if (!stop) exp_bus.push_back('{1'b0, 32'(ADDR_STATUS), 0, cyc + 2});
                        end
                    end
                    ADDR_ERROR: begin
                        prdata = {6'($urandom), 2'((offer_q.size() > 0) ? offer_q[0].err : 0)};
                        if (stop_on_err) begin
                            stop_rsp    = 1'b1;
                            stop_on_err = 1'b0;
                        end
                    end
                    ADDR_DATA: begin
                        prdata = 8'((offer_q.size() > 0) ? offer_q[0].data : 0);
                        if (offer_q.size() > 0) void'(offer_q.pop_front());
                        if (!stop) exp_bus.push_back('{1'b0, 32'(ADDR_STATUS), 0, cyc + 2});
                    end
                    default: prdata = 8'($urandom);
                endcase
            end
        end
    end

    bit         prev_setup = 1'b0;
    logic [2:0] prev_addr = '0;
    bus_t       e_bus;
    rx_t        e_rx;
    int         e_cfg;

    // Monitor: every observed transfer/strobe is matched against the queues
    always @(negedge clk) begin
        if (psel && penable) begin
            check("setup_precedes_access", longint'(prev_setup && prev_addr == paddr), 1);
            if (exp_bus.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_access: addr %0d wr %0b at cycle %0d, none expected", paddr, pwrite, cyc);
            end else begin
                e_bus = exp_bus.pop_front();
                check("access_addr", paddr, e_bus.addr);
                check("access_wr", pwrite, e_bus.wr);
                if (e_bus.wr) check("access_wdata", pwdata, e_bus.wdata);
                check("access_cycle", cyc, e_bus.cyc);
            end
        end
        prev_setup = psel && !penable;
        prev_addr  = paddr;

        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_valid: byte 0x%0h at cycle %0d, none expected", rx_byte, cyc);
            end else begin
                e_rx = exp_rx.pop_front();
                check("rx_byte", rx_byte, e_rx.data);
                check("rx_error", rx_error, e_rx.err);
                check("rx_cycle", cyc, e_rx.cyc);
            end
        end

        if (cfg_done) begin
            if (exp_cfg.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cfg_done: at cycle %0d, none expected", cyc);
            end else begin
                e_cfg = exp_cfg.pop_front();
                check("cfg_done_cycle", cyc, e_cfg);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start; n_wr config writes are expected (3 = full config then polling)
    task automatic do_start(input int unsigned bp, input int unsigned ds, input int n_wr);
        int s;
        int unsigned wd[3];
        s = cyc;
        wd[0] = bp & 32'hFF;
        wd[1] = (bp >> 8) & 32'h3F;
        wd[2] = ds & 32'hF;
        cfg_bit_period = 14'(bp);
        cfg_data_size  = 4'(ds);
        start = 1'b1;
        for (int i = 0; i < n_wr; i++) exp_bus.push_back('{1'b1, 32'(2 + i), wd[i], s + 2 + 2 * i});
        if (n_wr == 3) begin
            exp_cfg.push_back(s + 7);
            exp_bus.push_back('{1'b0, 32'(ADDR_STATUS), 0, s + 8});
        end
        tick(1);
        start = 1'b0;
    endtask

    task automatic offer_random(input int n);
        for (int i = 0; i < n; i++)
            offer_q.push_back('{int'($urandom_range(0, 6)), $urandom_range(0, 2), $urandom_range(0, 255)});
    endtask

    task automatic wait_drained(input string name, input int max);
        int n = 0;
        while ((offer_q.size() != 0 || exp_rx.size() != 0) && n < max) begin
            tick(1);
            n++;
        end
        check({name, "_drain_in_time"}, longint'(n < max), 1);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin
            tick(1);
            n++;
        end
        check({name, "_idle_in_time"}, longint'(n < max), 1);
        tick(2);
        check({name, "_no_pending_access"}, exp_bus.size(), 0);
        check({name, "_psel_low"}, psel, 0);
    endtask

    task automatic stop_and_idle(input string name);
        stop_stim = 1'b1;
        wait_idle(name, 40);
        stop_stim = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int act;

        // Reset state
        tick(3);
        check("reset_psel", psel, 0);
        check("reset_penable", penable, 0);
        check("reset_paddr", paddr, 0);
        check("reset_pwdata", pwdata, 0);
        check("reset_busy", busy, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_byte", rx_byte, 0);
        check("reset_bus_error", bus_error, 0);
        n_rst = 1'b1;
        tick(2);

        // Configuration and the two directed bytes, then random traffic
        offer_q.push_back('{5, 0, 32'h3C});
        offer_q.push_back('{0, 2, 32'hFF});
        offer_random(6);
        do_start(32'h2A5, 8, 3);
        check("busy_after_start", busy, 1);
        wait_drained("basic", 400);
        stop_and_idle("basic");

        // pslverr on the high bit-period write aborts configuration
        inj_en   = 1'b1;
        inj_addr = 3;
        do_start($urandom_range(0, 16383), $urandom_range(0, 15), 2);
        tick(10);
        check("slverr_bus_error", bus_error, 1);
        check("slverr_busy", busy, 0);
        check("slverr_no_pending", exp_bus.size(), 0);
        check("slverr_no_cfg_done", exp_cfg.size(), 0);
        offer_random(3);
        do_start($urandom_range(0, 16383), $urandom_range(0, 15), 3);
        check("restart_clears_bus_error", bus_error, 0);
        wait_drained("restart", 200);
        stop_and_idle("restart");

        // stop raised during the error-register read: byte still delivered, then idle
        stop_on_err = 1'b1;
        offer_q.push_back('{2, 1, $urandom_range(0, 255)});
        do_start($urandom_range(0, 16383), $urandom_range(0, 15), 3);
        wait_drained("stop_mid_byte", 100);
        wait_idle("stop_mid_byte", 20);
        check("stop_mid_byte_busy", busy, 0);

        // Reset during a status ACCESS
        do_start($urandom_range(0, 16383), $urandom_range(0, 15), 3);
        tick(12);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(psel && penable && paddr == ADDR_STATUS) && n < 20);
        check("found_poll_access", longint'(n < 20), 1);
        #1 n_rst = 1'b0;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rx_byte", rx_byte, 0);
        exp_bus.delete();
        tick(2);
        n_rst = 1'b1;
        act = 0;
        repeat (10) begin
            tick(1);
            if (psel || busy) act++;
        end
        check("quiet_after_reset", act, 0);

        // Operation resumes after a fresh start
        offer_random(2);
        do_start($urandom_range(0, 16383), $urandom_range(0, 15), 3);
        wait_drained("after_reset", 150);
        stop_and_idle("after_reset");

        check("rx_queue_empty", exp_rx.size(), 0);
        check("cfg_queue_empty", exp_cfg.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_uart_host.md
# apb_uart_host

APB initiator that drives the UART receiver's APB register interface from the host side. On a start pulse it programs bit period and data size, then repeatedly polls the data-status register. When a byte is available it reads the error register and the data buffer, and presents the byte with a one-cycle valid strobe. It connects directly to the receiver's APB responder port with zero wait states; the responder has no pready, so every ACCESS phase completes in one cycle.

## Interface
Parameters:
- none; register addresses and widths are fixed in `apb_uart_pkg`.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; honoured only in IDLE.
- `stop`  in  1  level; leave polling once the current transfer finishes.
- `cfg_bit_period`  in  14  bit period value, captured on start.
- `cfg_data_size`  in  4  data size value, captured on start.
- `psel`, `penable`, `pwrite`  out  1 each  APB controls.
- `paddr`  out  3  APB address.
- `pwdata`  out  8  APB write data.
- `prdata`  in  8  APB read data; valid during ACCESS.
- `pslverr`  in  1  responder error; valid during ACCESS.
- `rx_byte`  out  8  last received byte.
- `rx_error`  out  2  error-register value captured with that byte.
- `rx_valid`  out  1  one-cycle strobe marking a new `rx_byte`.
- `cfg_done`  out  1  one-cycle strobe after the last configuration write.
- `busy`  out  1  high in every state except IDLE.
- `bus_error`  out  1  sticky; set by `pslverr`.

## Operation
- Every APB transfer is two cycles:
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1.
- `prdata` and `pslverr` are sampled at the edge that ends ACCESS.
- The next SETUP may follow ACCESS immediately.
- Between transfers: `psel`=`penable`=0. `paddr`, `pwdata` and `pwrite` hold their last values.
- All APB outputs come from registers.
- Main FSM states: IDLE, CFG_BPL, CFG_BPH, CFG_DS, POLL, RD_ERR, RD_DATA.
  - IDLE -> CFG_BPL on `start`. Capture the configuration inputs, clear `bus_error`.
  - CFG_BPL: write addr 2, data = `bit_period[7:0]`.
  - CFG_BPH: write addr 3, data = {2'b00, `bit_period[13:8]`}.
  - CFG_DS: write addr 4, data = {4'b0, `data_size`}. On completion pulse `cfg_done` and go to POLL.
  - POLL: read addr 0.
    - `prdata[0]`=1 -> RD_ERR.
    - Otherwise poll again; the next SETUP is back-to-back.
  - RD_ERR: read addr 1 and capture `prdata[1:0]`, then go to RD_DATA.
  - RD_DATA: read addr 6. On completion load `rx_byte`, load `rx_error` from the captured value, pulse `rx_valid`, and return to POLL.
- `stop` is sampled only at completion of a POLL or RD_DATA transfer. If high, go to IDLE instead of POLL or RD_ERR.
- `stop` never aborts a byte between RD_ERR and RD_DATA.
- `pslverr`=1 on any transfer:
  - discard that transfer's result;
  - set `bus_error`, go to IDLE, and pulse neither `cfg_done` nor `rx_valid`.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0. FSM in IDLE. Captured configuration 0.
- `start` high at edge k gives:
  - SETUP of addr 2 in cycle k+1, ACCESS in k+2;
  - addr 3 in k+3/k+4, addr 4 in k+5/k+6;
  - `cfg_done` high in cycle k+7, together with the first POLL SETUP.
- A byte whose status read (ACCESS) ends at edge m gives:
  - RD_ERR in cycles m+1/m+2, RD_DATA in m+3/m+4;
  - `rx_valid` high in cycle m+5, with `rx_byte`/`rx_error` stable from then until the next byte.
- Poll period: 2 cycles.
- Reset asserted mid-transfer drops `psel`/`penable` immediately (asynchronous). No partial result is kept.

## Structure
- `apb_uart_pkg`:
  - address constants: STATUS=0, ERROR=1, BP_LO=2, BP_HI=3, DSIZE=4, DATA=6;
  - main FSM state enum;
  - error codes: NONE=0, FRAMING=1, OVERRUN=2.
- One sub-module, `apb_xfer`: a single-transfer engine.
  - Request handshake: `req`, `wr`, `addr`, `wdata`.
  - Response: `done` pulse with `rdata` and `err`.
  - States: IDLE, SETUP, ACCESS.
  - `req` during the `done` cycle starts the next SETUP with no gap.
- The top level holds only the main FSM and the captured registers.

## Test plan
- Reset, then start with `bit_period`=0x2A5 and `data_size`=8 -> exactly these three writes:
  - addr2/0xA5, addr3/0x02, addr4/0x08;
  - `cfg_done` in cycle k+7.
- Responder status 0 for 5 polls, then status 1, error 0, data 0x3C -> `rx_valid` once, `rx_byte`=0x3C, `rx_error`=0, exactly 5 cycles after the status ACCESS.
- Status 1 with error register 2 and data 0xFF -> `rx_error`=2, `rx_byte`=0xFF. Then polling resumes with back-to-back 2-cycle transfers.
- `pslverr` during the CFG_BPH ACCESS -> `bus_error`=1, IDLE, no `cfg_done`. A following start clears `bus_error` and reconfigures.
- `stop` raised during RD_ERR -> RD_DATA still completes and `rx_valid` pulses, then IDLE with `busy`=0.
- `n_rst` pulled low during a POLL ACCESS -> `psel`/`penable`/`busy` drop in the same cycle. After release, no bus activity until `start`.
